// File: rtl/keyboard_ctl_pkg.sv
// Shared scan-code constants and state types for the keyboard controller.
package keyboard_ctl_pkg;

  localparam int unsigned KEY_W = 16;

  // ASCII-hex encoded PS/2 set-2 scan codes
  localparam logic [KEY_W-1:0] A        = 16'h3143;
  localparam logic [KEY_W-1:0] D        = 16'h3233;
  localparam logic [KEY_W-1:0] SPACE    = 16'h3239;
  localparam logic [KEY_W-1:0] ENTER    = 16'h3541;
  localparam logic [KEY_W-1:0] RELEASED = 16'h4630;
  localparam logic [KEY_W-1:0] EXTENDED = 16'h4530;

  typedef enum logic {IDLE, BREAK} kbd_state_t;

  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} kbd_dir_t;

endpackage

// File: rtl/keyboard_ctl.sv
// Turns raw scan-code words into held movement levels and one-shot action pulses.
module keyboard_ctl
  import keyboard_ctl_pkg::*;
#(
  parameter int unsigned BREAK_TIMEOUT = 100_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] keyCode,
  input  logic             keyValid,
  output logic             moveLeft,
  output logic             moveRight,
  output logic             jumpPulse,
  output logic             enterPulse,
  output logic             anyKeyHeld
);

  localparam int unsigned CNT_W = (BREAK_TIMEOUT > 0) ? $clog2(BREAK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BREAK_TIMEOUT - 32'd1);

  kbd_state_t       state, state_nxt;
  kbd_dir_t         last_dir, dir_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             a_held, d_held, space_held, enter_held;
  logic             a_nxt, d_nxt, space_nxt, enter_nxt;
  logic             left_nxt, right_nxt, jump_nxt, enter_pulse_nxt, any_nxt;
  logic             do_make, do_break;

  // State, held flags, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_dir   <= DIR_NONE;
      cnt        <= '0;
      a_held     <= 1'b0;
      d_held     <= 1'b0;
      space_held <= 1'b0;
      enter_held <= 1'b0;
      moveLeft   <= 1'b0;
      moveRight  <= 1'b0;
      jumpPulse  <= 1'b0;
      enterPulse <= 1'b0;
      anyKeyHeld <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_dir   <= dir_nxt;
      cnt        <= cnt_nxt;
      a_held     <= a_nxt;
      d_held     <= d_nxt;
      space_held <= space_nxt;
      enter_held <= enter_nxt;
      moveLeft   <= left_nxt;
      moveRight  <= right_nxt;
      jumpPulse  <= jump_nxt;
      enterPulse <= enter_pulse_nxt;
      anyKeyHeld <= any_nxt;
    end
  end

  // Next-state decode, make/break bookkeeping and output derivation
  always_comb begin
    state_nxt       = state;
    dir_nxt         = last_dir;
    cnt_nxt         = cnt;
    a_nxt           = a_held;
    d_nxt           = d_held;
    space_nxt       = space_held;
    enter_nxt       = enter_held;
    jump_nxt        = 1'b0;
    enter_pulse_nxt = 1'b0;
    do_make         = 1'b0;
    do_break        = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (keyValid) begin
          if (keyCode == RELEASED) begin
            state_nxt = BREAK;
          end else if (keyCode == A || keyCode == D ||
                       keyCode == SPACE || keyCode == ENTER) begin
            do_make = 1'b1;
          end
        end
      end
      BREAK: begin
        if (keyValid) begin
          cnt_nxt = '0;
          if (keyCode == A || keyCode == D ||
              keyCode == SPACE || keyCode == ENTER) begin
            do_break  = 1'b1;
            state_nxt = IDLE;
          end else if (keyCode != EXTENDED && keyCode != RELEASED) begin
            state_nxt = IDLE;
          end
        end else if (BREAK_TIMEOUT != 0 && cnt >= CNT_LAST) begin
          // Lost the key that should follow the release prefix; held flags stay as-is
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (do_make) begin
      if (keyCode == A) begin
        a_nxt   = 1'b1;
        dir_nxt = DIR_LEFT;
      end else if (keyCode == D) begin
        d_nxt   = 1'b1;
        dir_nxt = DIR_RIGHT;
      end else if (keyCode == SPACE) begin
        space_nxt = 1'b1;
        jump_nxt  = !space_held;
      end else begin
        enter_nxt       = 1'b1;
        enter_pulse_nxt = !enter_held;
      end
    end

    if (do_break) begin
      if (keyCode == A) begin
        a_nxt = 1'b0;
        if (last_dir == DIR_LEFT) dir_nxt = d_held ? DIR_RIGHT : DIR_NONE;
      end else if (keyCode == D) begin
        d_nxt = 1'b0;
        if (last_dir == DIR_RIGHT) dir_nxt = a_held ? DIR_LEFT : DIR_NONE;
      end else if (keyCode == SPACE) begin
        space_nxt = 1'b0;
      end else begin
        enter_nxt = 1'b0;
      end
    end

    left_nxt  = a_nxt && (dir_nxt == DIR_LEFT);
    right_nxt = d_nxt && (dir_nxt == DIR_RIGHT);
    any_nxt   = a_nxt || d_nxt || space_nxt || enter_nxt;
  end

endmodule

// File: tb/tb_keyboard_ctl.sv
// Scoreboard bench for keyboard_ctl: driver queues expected output vectors, monitor checks them.
module tb_keyboard_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keyCode;
  logic        keyValid;
  logic        moveLeft, moveRight, jumpPulse, enterPulse, anyKeyHeld;

  typedef struct {
    logic [4:0]  exp;
    int          issue;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cycle = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  keyboard_ctl #(.BREAK_TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .keyCode    (keyCode),
    .keyValid   (keyValid),
    .moveLeft   (moveLeft),
    .moveRight  (moveRight),
    .jumpPulse  (jumpPulse),
    .enterPulse (enterPulse),
    .anyKeyHeld (anyKeyHeld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Output vector order: {moveLeft, moveRight, jumpPulse, enterPulse, anyKeyHeld}
  function automatic void cmp(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got L R J E H = %b, expected %b", name, act, exp);
    end
  endfunction

  // Monitor: each expectation is checked on the first falling edge after the edge it targets
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].issue < cycle) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.name, {moveLeft, moveRight, jumpPulse, enterPulse, anyKeyHeld}, e.exp);
    end
  end

  task automatic send(input logic [15:0] code, input logic [4:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    keyCode  = code;
    keyValid = 1'b1;
    e.exp = exp; e.issue = cycle; e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1 keyValid = 1'b0;
  endtask

  task automatic idle(input logic [4:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    e.exp = exp; e.issue = cycle; e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_with_key(input logic [15:0] code, input string name);
    exp_t e;
    @(negedge clk);
    rst      = 1'b1;
    keyCode  = code;
    keyValid = 1'b1;
    e.exp = 5'b00000; e.issue = cycle; e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1 begin rst = 1'b0; keyValid = 1'b0; end
  endtask

  initial begin
    rst = 1'b1; keyValid = 1'b0; keyCode = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("reset_state", {moveLeft, moveRight, jumpPulse, enterPulse, anyKeyHeld}, 5'b00000);
    rst = 1'b0;

    // Direction: last-pressed wins, fallback to still-held key
    send(16'h3143, 5'b10001, "a_make");
    send(16'h3233, 5'b01001, "d_make_over_a");
    send(16'h4630, 5'b01001, "rel_prefix");
    send(16'h3233, 5'b10001, "d_break_back_to_a");
    send(16'h4630, 5'b10001, "rel_prefix2");
    send(16'h3143, 5'b00000, "a_break");

    // SPACE typematic: one pulse per fresh press
    send(16'h3239, 5'b00101, "space_make");
    send(16'h3239, 5'b00001, "space_repeat1");
    send(16'h3239, 5'b00001, "space_repeat2");
    send(16'h4630, 5'b00001, "space_rel_prefix");
    send(16'h3239, 5'b00000, "space_break");
    send(16'h3239, 5'b00101, "space_make_again");
    idle(5'b00001, "jump_one_cycle");
    send(16'h4630, 5'b00001, "space_rel_prefix2");
    send(16'h3239, 5'b00000, "space_break2");

    // Timeout out of BREAK, then ENTER is a make
    send(16'h4630, 5'b00000, "to_rel_prefix");
    for (int i = 0; i < 10; i++) idle(5'b00000, "to_wait");
    send(16'h3541, 5'b00011, "enter_after_timeout");
    idle(5'b00001, "enter_one_cycle");
    send(16'h4630, 5'b00001, "enter_rel_prefix");
    send(16'h3541, 5'b00000, "enter_break");

    // Extended prefix is transparent
    send(16'h4530, 5'b00000, "ext_idle");
    send(16'h3233, 5'b01001, "ext_d_make");
    send(16'h4530, 5'b01001, "ext_before_rel");
    send(16'h4630, 5'b01001, "ext_rel");
    send(16'h3233, 5'b00000, "ext_d_break");

    // Unlisted codes and stray breaks
    send(16'h1234, 5'b00000, "unknown_idle");
    send(16'h4630, 5'b00000, "stray_rel");
    send(16'h3143, 5'b00000, "break_not_held");
    send(16'h4630, 5'b00000, "rel_then_other");
    send(16'h1234, 5'b00000, "other_in_break");
    send(16'h3143, 5'b10001, "a_make_after_other");
    send(16'h4630, 5'b10001, "a_rel_prefix");
    send(16'h3143, 5'b00000, "a_break2");

    // Reset beats a simultaneous key
    send(16'h3233, 5'b01001, "d_hold_before_rst");
    reset_with_key(16'h3143, "rst_over_key");
    idle(5'b00000, "after_rst");

    // Drain scoreboard with a bounded wait
    begin
      int guard = 0;
      while (exp_q.size() > 0 && guard < 100) begin
        @(posedge clk);
        guard++;
      end
      if (exp_q.size() > 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
